// File: rtl/data_structures.sv
// Shared types for the load/store path: functional-unit opcodes, the LS
// controller state encoding and the latched instruction record.
package data_structures;

    localparam int DS_GPR_SIZE     = 64;
    localparam int DS_ROB_IDX_SIZE = 6;

    typedef enum logic [1:0] {
        FU_OP_NOP  = 2'd0,
        FU_OP_LDUR = 2'd1,
        FU_OP_STUR = 2'd2,
        FU_OP_ADD  = 2'd3
    } fu_op_t;

    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_REQ  = 2'd1,
        LS_RESP = 2'd2
    } ls_state_t;

    // Everything captured from the reservation station at issue time.
    typedef struct packed {
        fu_op_t                     op;
        logic [DS_GPR_SIZE-1:0]     addr;
        logic [DS_GPR_SIZE-1:0]     data;
        logic [DS_ROB_IDX_SIZE-1:0] dst_rob_index;
        logic                       fault;
    } ls_entry_t;

endpackage

// File: rtl/ls_functional_unit.sv
// Load/store functional unit: one instruction in flight, alignment check,
// single-outstanding req/ack memory port, result held until the ROB takes it.
module ls_functional_unit
    import data_structures::*;
#(
    parameter int GPR_SIZE     = DS_GPR_SIZE,
    parameter int ROB_IDX_SIZE = DS_ROB_IDX_SIZE,
    parameter int ALIGN_BITS   = 3
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic                    in_rs_start,
    input  fu_op_t                  in_rs_op,
    input  logic [GPR_SIZE-1:0]     in_rs_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
    output logic                    out_fu_ready,
    output logic                    out_mem_req,
    output logic                    out_mem_we,
    output logic [GPR_SIZE-1:0]     out_mem_addr,
    output logic [GPR_SIZE-1:0]     out_mem_wdata,
    input  logic                    in_mem_ack,
    input  logic [GPR_SIZE-1:0]     in_mem_rdata,
    output logic                    out_rob_done,
    output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [GPR_SIZE-1:0]     out_rob_value,
    output logic                    out_rob_fault,
    input  logic                    in_rob_ack,
    input  logic                    in_flush
);

    ls_state_t           state, state_n;
    ls_entry_t           entry, entry_n;
    logic                flush_pending, flush_pending_n;
    logic [GPR_SIZE-1:0] rob_value, rob_value_n;

    // Next-state decode. Priority: flush, then mem/rob ack, then start.
    always_comb begin
        state_n         = state;
        entry_n         = entry;
        flush_pending_n = flush_pending;
        rob_value_n     = rob_value;
        case (state)
            LS_IDLE: begin
                flush_pending_n = 1'b0;
                if (in_rs_start && !in_flush) begin
                    entry_n.op            = in_rs_op;
                    entry_n.addr          = in_rs_val_a;
                    entry_n.data          = in_rs_val_b;
                    entry_n.dst_rob_index = in_rs_dst_rob_index;
                    // Misaligned or non-memory ops complete as faults without touching memory.
                    entry_n.fault = (in_rs_val_a[ALIGN_BITS-1:0] != '0) ||
                                    !((in_rs_op == FU_OP_LDUR) || (in_rs_op == FU_OP_STUR));
                    rob_value_n   = '0;
                    state_n       = entry_n.fault ? LS_RESP : LS_REQ;
                end
            end
            LS_REQ: begin
                if (in_mem_ack) begin
                    // A flush arriving with the ack still kills the result.
                    if (in_flush || flush_pending) begin
                        state_n         = LS_IDLE;
                        flush_pending_n = 1'b0;
                    end else begin
                        state_n     = LS_RESP;
                        rob_value_n = (entry.op == FU_OP_LDUR) ? in_mem_rdata : '0;
                    end
                end else if (in_flush) begin
                    // The bus transaction must complete; remember to drop it.
                    flush_pending_n = 1'b1;
                end
            end
            LS_RESP: begin
                if (in_flush || in_rob_ack) state_n = LS_IDLE;
            end
            default: state_n = LS_IDLE;
        endcase
    end

    // State and latched-instruction registers; reset aborts any transaction.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state         <= LS_IDLE;
            entry         <= '0;
            flush_pending <= 1'b0;
            rob_value     <= '0;
        end else begin
            state         <= state_n;
            entry         <= entry_n;
            flush_pending <= flush_pending_n;
            rob_value     <= rob_value_n;
        end
    end

    // Outputs come only from state and latched registers.
    assign out_fu_ready          = (state == LS_IDLE);
    assign out_mem_req           = (state == LS_REQ);
    assign out_mem_we            = (state == LS_REQ) && (entry.op == FU_OP_STUR);
    assign out_mem_addr          = entry.addr;
    assign out_mem_wdata         = entry.data;
    assign out_rob_done          = (state == LS_RESP);
    assign out_rob_dst_rob_index = entry.dst_rob_index;
    assign out_rob_value         = rob_value;
    assign out_rob_fault         = (state == LS_RESP) && entry.fault;

    // Issuing into a busy unit is an RS bug; the start is dropped.
    a_start_when_busy: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        !(in_rs_start && !out_fu_ready));

endmodule

// File: tb/tb_ls_functional_unit.sv
// Self-checking bench for ls_functional_unit: table-driven op vectors with a
// result scoreboard, plus hand sequences for flush, ROB stall and reset.
module tb_ls_functional_unit;
    import data_structures::*;

    logic        in_clk = 1'b0;
    logic        in_rst_n = 1'b0;
    logic        in_rs_start = 1'b0;
    fu_op_t      in_rs_op = FU_OP_NOP;
    logic [63:0] in_rs_val_a = '0;
    logic [63:0] in_rs_val_b = '0;
    logic [5:0]  in_rs_dst_rob_index = '0;
    logic        out_fu_ready, out_mem_req, out_mem_we;
    logic [63:0] out_mem_addr, out_mem_wdata;
    logic        in_mem_ack = 1'b0;
    logic [63:0] in_mem_rdata = '0;
    logic        out_rob_done;
    logic [5:0]  out_rob_dst_rob_index;
    logic [63:0] out_rob_value;
    logic        out_rob_fault;
    logic        in_rob_ack = 1'b0;
    logic        in_flush = 1'b0;

    ls_functional_unit dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n),
        .in_rs_start(in_rs_start), .in_rs_op(in_rs_op),
        .in_rs_val_a(in_rs_val_a), .in_rs_val_b(in_rs_val_b),
        .in_rs_dst_rob_index(in_rs_dst_rob_index),
        .out_fu_ready(out_fu_ready), .out_mem_req(out_mem_req), .out_mem_we(out_mem_we),
        .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
        .in_mem_ack(in_mem_ack), .in_mem_rdata(in_mem_rdata),
        .out_rob_done(out_rob_done), .out_rob_dst_rob_index(out_rob_dst_rob_index),
        .out_rob_value(out_rob_value), .out_rob_fault(out_rob_fault),
        .in_rob_ack(in_rob_ack), .in_flush(in_flush)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        fu_op_t      op;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  tag;
        int          ack_delay;
        logic [63:0] rdata;
        logic        exp_we;
        logic [63:0] exp_value;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [5:0]  tag;
        logic [63:0] value;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare.
    task automatic take_result(input string name);
        exp_t e;
        int n = 0;
        while (!out_rob_done && n < 20) begin tick(); n++; end
        chk({name, "_done"}, out_rob_done, 1'b1);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({name, "_tag"}, out_rob_dst_rob_index, e.tag);
            chk({name, "_value"}, out_rob_value, e.value);
            chk({name, "_fault"}, out_rob_fault, e.fault);
        end
    endtask

    task automatic issue(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] tag);
        in_rs_start = 1'b1; in_rs_op = op; in_rs_val_a = a; in_rs_val_b = b;
        in_rs_dst_rob_index = tag;
        tick();
        in_rs_start = 1'b0;
    endtask

    task automatic mem_ack(input logic [63:0] rdata);
        in_mem_ack = 1'b1; in_mem_rdata = rdata;
        tick();
        in_mem_ack = 1'b0; in_mem_rdata = '0;
    endtask

    task automatic do_op(input vec_t v, input string name);
        exp_t e;
        e.tag = v.tag; e.value = v.exp_value; e.fault = v.exp_fault;
        sb.push_back(e);
        issue(v.op, v.a, v.b, v.tag);
        chk({name, "_busy"}, out_fu_ready, 1'b0);
        if (!v.exp_fault) begin
            chk({name, "_req"}, out_mem_req, 1'b1);
            chk({name, "_we"}, out_mem_we, v.exp_we);
            chk({name, "_addr"}, out_mem_addr, v.a);
            if (v.exp_we) chk({name, "_wdata"}, out_mem_wdata, v.b);
            for (int i = 0; i < v.ack_delay; i++) begin
                tick();
                chk({name, "_req_hold"}, out_mem_req, 1'b1);
                chk({name, "_addr_hold"}, out_mem_addr, v.a);
            end
            mem_ack(v.rdata);
            chk({name, "_req_drop"}, out_mem_req, 1'b0);
        end else begin
            chk({name, "_no_req"}, out_mem_req, 1'b0);
        end
        take_result(name);
        in_rob_ack = 1'b1;
        tick();
        in_rob_ack = 1'b0;
        chk({name, "_done_clr"}, out_rob_done, 1'b0);
        chk({name, "_ready_back"}, out_fu_ready, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, out_fu_ready, 1'b1);
        chk({name, "_req"}, out_mem_req, 1'b0);
        chk({name, "_we"}, out_mem_we, 1'b0);
        chk({name, "_addr"}, out_mem_addr, 64'd0);
        chk({name, "_wdata"}, out_mem_wdata, 64'd0);
        chk({name, "_done"}, out_rob_done, 1'b0);
        chk({name, "_value"}, out_rob_value, 64'd0);
        chk({name, "_tag"}, out_rob_dst_rob_index, 6'd0);
        chk({name, "_fault"}, out_rob_fault, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        exp_t e;
        vecs[0] = '{FU_OP_LDUR, 64'h100, 64'h0, 6'd5, 3, 64'hDEADBEEF, 1'b0, 64'hDEADBEEF, 1'b0};
        vecs[1] = '{FU_OP_STUR, 64'h208, 64'd42, 6'd2, 1, 64'h1234, 1'b1, 64'h0, 1'b0};
        vecs[2] = '{FU_OP_LDUR, 64'h103, 64'h0, 6'd7, 0, 64'h0, 1'b0, 64'h0, 1'b1};
        vecs[3] = '{FU_OP_STUR, 64'h20C, 64'h77, 6'd8, 0, 64'h0, 1'b0, 64'h0, 1'b1};
        vecs[4] = '{FU_OP_LDUR, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 6'd63, 0,
                    64'hA5A5_5A5A_0123_4567, 1'b0, 64'hA5A5_5A5A_0123_4567, 1'b0};
        vecs[5] = '{FU_OP_ADD, 64'h40, 64'h1, 6'd11, 0, 64'h0, 1'b0, 64'h0, 1'b1};
        vecs[6] = '{FU_OP_STUR, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 2, 64'hBAD, 1'b1, 64'h0, 1'b0};

        #1;
        chk_reset_outputs("rst");
        repeat (2) @(posedge in_clk);
        #3 in_rst_n = 1'b1;
        tick();
        chk("post_rst_ready", out_fu_ready, 1'b1);

        for (int i = 0; i < 7; i++) do_op(vecs[i], $sformatf("vec%0d", i));

        // Flush during LS_REQ: request finishes, result is dropped.
        issue(FU_OP_LDUR, 64'h300, 64'h0, 6'd9);
        chk("flq_req", out_mem_req, 1'b1);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        chk("flq_req_kept", out_mem_req, 1'b1);
        chk("flq_no_done0", out_rob_done, 1'b0);
        tick();
        chk("flq_req_kept2", out_mem_req, 1'b1);
        mem_ack(64'h1111);
        chk("flq_ready", out_fu_ready, 1'b1);
        chk("flq_no_done1", out_rob_done, 1'b0);
        tick();
        chk("flq_no_done2", out_rob_done, 1'b0);

        // Flush together with ack in LS_REQ also drops the result.
        issue(FU_OP_LDUR, 64'h310, 64'h0, 6'd10);
        in_flush = 1'b1;
        mem_ack(64'h2222);
        in_flush = 1'b0;
        chk("flack_ready", out_fu_ready, 1'b1);
        chk("flack_no_done", out_rob_done, 1'b0);

        // ROB stall: result held stable for 5 cycles.
        e.tag = 6'd3; e.value = 64'hCAFE; e.fault = 1'b0;
        sb.push_back(e);
        issue(FU_OP_LDUR, 64'h500, 64'h0, 6'd3);
        mem_ack(64'hCAFE);
        take_result("stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_done", out_rob_done, 1'b1);
            chk("stall_tag", out_rob_dst_rob_index, 6'd3);
            chk("stall_value", out_rob_value, 64'hCAFE);
            chk("stall_ready", out_fu_ready, 1'b0);
        end
        in_rob_ack = 1'b1;
        tick();
        in_rob_ack = 1'b0;
        chk("stall_release", out_fu_ready, 1'b1);

        // Flush in LS_RESP with a same-cycle rob ack.
        issue(FU_OP_LDUR, 64'h601, 64'h0, 6'd12);
        chk("flr_done", out_rob_done, 1'b1);
        chk("flr_fault", out_rob_fault, 1'b1);
        in_flush = 1'b1; in_rob_ack = 1'b1;
        tick();
        in_flush = 1'b0; in_rob_ack = 1'b0;
        chk("flr_done_clr", out_rob_done, 1'b0);
        chk("flr_ready", out_fu_ready, 1'b1);

        // Start with flush in LS_IDLE is ignored.
        in_flush = 1'b1;
        issue(FU_OP_LDUR, 64'h700, 64'h0, 6'd13);
        in_flush = 1'b0;
        chk("fli_ready", out_fu_ready, 1'b1);
        chk("fli_no_req", out_mem_req, 1'b0);
        chk("fli_no_done", out_rob_done, 1'b0);

        // Async reset during LS_REQ clears everything before any clock edge.
        issue(FU_OP_STUR, 64'h808, 64'h5, 6'd14);
        chk("rreq_req", out_mem_req, 1'b1);
        #2 in_rst_n = 1'b0;
        #1;
        chk_reset_outputs("rreq");
        tick();
        #2 in_rst_n = 1'b1;
        tick();
        chk("rreq_ready_after", out_fu_ready, 1'b1);
        chk("rreq_no_req_after", out_mem_req, 1'b0);

        // Unit works normally after the mid-transaction reset.
        do_op(vecs[0], "after_rst");

        chk("sb_drained", sb.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
